// File: rtl/grid_click_pkg.sv
// Shared state encoding, default grid geometry and width helpers for the
// grid click decoder.
package grid_click_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_HOLD
  } state_e;

  localparam int unsigned DEF_N_COLS   = 8;
  localparam int unsigned DEF_N_ROWS   = 8;
  localparam int unsigned DEF_X_ORIGIN = 17;
  localparam int unsigned DEF_Y_ORIGIN = 8;
  localparam int unsigned DEF_CELL_W   = 20;
  localparam int unsigned DEF_CELL_H   = 20;
  localparam int unsigned DEF_PITCH_X  = 37;
  localparam int unsigned DEF_PITCH_Y  = 28;
  localparam int unsigned DEF_X_W      = 10;
  localparam int unsigned DEF_Y_W      = 9;

  localparam int unsigned DROP_W = 8;

  // Index width for n cells; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axis_locator.sv
// Locates one coordinate on a regular cell grid by repeated pitch subtraction;
// hit/index are valid once enough steps have elapsed after load.
module axis_locator import grid_click_pkg::*; #(
  parameter int unsigned ORIGIN = DEF_X_ORIGIN,
  parameter int unsigned CELL   = DEF_CELL_W,
  parameter int unsigned PITCH  = DEF_PITCH_X,
  parameter int unsigned N      = DEF_N_COLS,
  parameter int unsigned W      = DEF_X_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_i,
  input  logic                   step_en_i,
  input  logic [W-1:0]           coord_i,
  output logic                   hit_o,
  output logic [idx_w(N)-1:0]    idx_o
);

  localparam int unsigned IW = idx_w(N);

  localparam logic [W-1:0]  ORG  = W'(ORIGIN);
  localparam logic [W-1:0]  PIT  = W'(PITCH);
  localparam logic [W-1:0]  CEL  = W'(CELL);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [W-1:0]  rem_q;
  logic [IW-1:0] idx_q;
  logic          below_q;

  // Stepping stops at the last cell; any remainder left then is >= PITCH >= CELL,
  // so far-out coordinates miss without the index wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q   <= '0;
      idx_q   <= '0;
      below_q <= 1'b1;
    end else if (load_i) begin
      below_q <= (coord_i < ORG);
      rem_q   <= coord_i - ORG;
      idx_q   <= '0;
    end else if (step_en_i && !below_q && (rem_q >= PIT) && (idx_q != LAST)) begin
      rem_q <= rem_q - PIT;
      idx_q <= idx_q + IW'(1);
    end
  end

  assign hit_o = !below_q && (rem_q < CEL);
  assign idx_o = idx_q;

endmodule

// File: rtl/grid_click_decoder.sv
// Turns an asynchronous mouse-button click into a registered grid cell hit
// result with fixed search latency and a saturating lost-click counter.
module grid_click_decoder import grid_click_pkg::*; #(
  parameter int unsigned N_COLS   = DEF_N_COLS,
  parameter int unsigned N_ROWS   = DEF_N_ROWS,
  parameter int unsigned X_ORIGIN = DEF_X_ORIGIN,
  parameter int unsigned Y_ORIGIN = DEF_Y_ORIGIN,
  parameter int unsigned CELL_W   = DEF_CELL_W,
  parameter int unsigned CELL_H   = DEF_CELL_H,
  parameter int unsigned PITCH_X  = DEF_PITCH_X,
  parameter int unsigned PITCH_Y  = DEF_PITCH_Y,
  parameter int unsigned X_W      = DEF_X_W,
  parameter int unsigned Y_W      = DEF_Y_W
) (
  input  logic                        clk,
  input  logic                        iReset,
  input  logic [X_W-1:0]              mouseX,
  input  logic [Y_W-1:0]              mouseY,
  input  logic                        iBtn,
  input  logic                        iEnable,
  input  logic                        iReady,
  output logic                        oValid,
  output logic                        oHit,
  output logic [idx_w(N_COLS)-1:0]    oBoxX,
  output logic [idx_w(N_ROWS)-1:0]    oBoxY,
  output logic [DROP_W-1:0]           oDropCnt
);

  localparam int unsigned XIW        = idx_w(N_COLS);
  localparam int unsigned YIW        = idx_w(N_ROWS);
  localparam int unsigned SEARCH_LEN = max_u(N_COLS, N_ROWS);
  localparam int unsigned CW         = idx_w(SEARCH_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(SEARCH_LEN - 1);

  logic       btn_s1_q, btn_s2_q, btn_prev_q;
  logic [1:0] warm_q;
  logic       click;

  // The previous-level flop resets high and only starts tracking once the
  // synchronizer holds post-reset data, so a button held through reset
  // release never looks like a fresh press.
  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_prev_q <= 1'b1;
      warm_q     <= '0;
    end else begin
      btn_s1_q <= iBtn;
      btn_s2_q <= btn_s1_q;
      if (warm_q != 2'd2) begin
        warm_q <= warm_q + 2'd1;
      end else begin
        btn_prev_q <= btn_s2_q;
      end
    end
  end

  assign click = btn_s2_q && !btn_prev_q;

  // Coordinates registered every cycle so the value captured is the one
  // present at the edge on which the synchronized level rose.
  logic [X_W-1:0] mx_q;
  logic [Y_W-1:0] my_q;

  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      mx_q <= '0;
      my_q <= '0;
    end else begin
      mx_q <= mouseX;
      my_q <= mouseY;
    end
  end

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            start;
  logic            step_en;
  logic            hit_x, hit_y;
  logic [XIW-1:0]  idx_x;
  logic [YIW-1:0]  idx_y;

  assign start   = click && iEnable && (state_q == ST_IDLE);
  assign step_en = (state_q == ST_SEARCH);

  axis_locator #(
    .ORIGIN (X_ORIGIN),
    .CELL   (CELL_W),
    .PITCH  (PITCH_X),
    .N      (N_COLS),
    .W      (X_W)
  ) u_loc_x (
    .clk_i     (clk),
    .rst_ni    (iReset),
    .load_i    (start),
    .step_en_i (step_en),
    .coord_i   (mx_q),
    .hit_o     (hit_x),
    .idx_o     (idx_x)
  );

  axis_locator #(
    .ORIGIN (Y_ORIGIN),
    .CELL   (CELL_H),
    .PITCH  (PITCH_Y),
    .N      (N_ROWS),
    .W      (Y_W)
  ) u_loc_y (
    .clk_i     (clk),
    .rst_ni    (iReset),
    .load_i    (start),
    .step_en_i (step_en),
    .coord_i   (my_q),
    .hit_o     (hit_y),
    .idx_o     (idx_y)
  );

  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      oValid   <= 1'b0;
      oHit     <= 1'b0;
      oBoxX    <= '0;
      oBoxY    <= '0;
      oDropCnt <= '0;
    end else begin
      if (click && (state_q != ST_IDLE) && (oDropCnt != '1)) begin
        oDropCnt <= oDropCnt + DROP_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (click && iEnable) begin
            state_q <= ST_SEARCH;
            cnt_q   <= '0;
          end
        end
        ST_SEARCH: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_HOLD;
            oValid  <= 1'b1;
            oHit    <= hit_x && hit_y;
            oBoxX   <= (hit_x && hit_y) ? idx_x : '0;
            oBoxY   <= (hit_x && hit_y) ? idx_y : '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_HOLD: begin
          if (iReady) begin
            state_q <= ST_IDLE;
            oValid  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
